uklad_przerwan: RTL and testbench

//  Interrupt controller: consumer end of the peripheral interrupt lines (timer licznik_int on src 0).

---
 rtl/uklad_przerwan_pkg.sv | 19 +
 rtl/uklad_przerwan_koder.sv | 22 ++
 rtl/uklad_przerwan.sv | 144 ++++++++++++++
 tb/tb_uklad_przerwan.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uklad_przerwan_pkg.sv
// Shared types and constants for the uklad_przerwan interrupt controller.
package uklad_przerwan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } stan_t;

    localparam int N_SRC_DEF = 4;
    localparam int VEC_W_DEF = 3;

    // Source index map; lower index means higher priority
    localparam int SRC_LICZNIK = 0;
    localparam int SRC_1       = 1;
    localparam int SRC_2       = 2;
    localparam int SRC_3       = 3;

endpackage

// File: rtl/uklad_przerwan_koder.sv
// Combinational priority encoder: reports the lowest set index of elig.
module koder_priorytetu #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 3
) (
    input  logic [N_SRC-1:0] elig,
    output logic [VEC_W-1:0] winner,
    output logic             any
);

    always_comb begin
        winner = '0;
        // Scan downwards so the lowest set index is the last one written
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = VEC_W'(i);
            end
        end
        any = |elig;
    end

endmodule

// File: rtl/uklad_przerwan.sv
// Interrupt controller: edge-detected pending sources, CPU mask, fixed priority
// and a non-nesting req/ack/return handshake with the CPU.
module uklad_przerwan
    import uklad_przerwan_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int VEC_W = VEC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [7:0]       wartosc,
    input  logic             zapisz_mask,
    input  logic             zapisz_clr,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic [7:0]       pending_o,
    output logic [7:0]       mask_o,
    output logic             in_service
);

    stan_t            stan, stan_nxt;
    logic [N_SRC-1:0] irq_prev;
    logic [N_SRC-1:0] pending, pend_nxt;
    logic [N_SRC-1:0] mask;
    logic             gie;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] vec_onehot;
    logic             vec_elig;
    logic [VEC_W-1:0] winner;
    logic             any_elig;
    logic             req_nxt, srv_nxt, ack_take;
    logic [VEC_W-1:0] vec_nxt;
    logic             unused_wr;

    // Bits [6:N_SRC] of the write data have no backing register
    assign unused_wr = ^wartosc;

    assign elig = pending & mask & {N_SRC{gie}};

    koder_priorytetu #(
        .N_SRC (N_SRC),
        .VEC_W (VEC_W)
    ) u_koder (
        .elig   (elig),
        .winner (winner),
        .any    (any_elig)
    );

    always_comb begin
        vec_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            vec_onehot[i] = (int_vec == VEC_W'(i));
        end
        vec_elig = |(elig & vec_onehot);
    end

    always_comb begin
        stan_nxt = stan;
        req_nxt  = int_req;
        vec_nxt  = int_vec;
        srv_nxt  = in_service;
        ack_take = 1'b0;
        case (stan)
            IDLE: begin
                if (any_elig) begin
                    stan_nxt = REQ;
                    req_nxt  = 1'b1;
                    vec_nxt  = winner;
                end
            end
            REQ: begin
                // Ack takes precedence over a simultaneous withdraw
                if (int_ack) begin
                    ack_take = 1'b1;
                    stan_nxt = SERVICE;
                    req_nxt  = 1'b0;
                    srv_nxt  = 1'b1;
                end else if (!vec_elig) begin
                    stan_nxt = IDLE;
                    req_nxt  = 1'b0;
                end
            end
            SERVICE: begin
                if (int_ret) begin
                    stan_nxt = IDLE;
                    srv_nxt  = 1'b0;
                end
            end
            default: begin
                stan_nxt = IDLE;
                req_nxt  = 1'b0;
                srv_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        pend_nxt = pending;
        if (zapisz_clr) begin
            pend_nxt = pend_nxt & ~wartosc[N_SRC-1:0];
        end
        if (ack_take) begin
            pend_nxt = pend_nxt & ~vec_onehot;
        end
        // A fresh edge overrides any clear in the same cycle
        pend_nxt = pend_nxt | (irq_src & ~irq_prev);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stan       <= IDLE;
            irq_prev   <= '0;
            pending    <= '0;
            mask       <= '0;
            gie        <= 1'b0;
            int_req    <= 1'b0;
            int_vec    <= '0;
            in_service <= 1'b0;
        end else begin
            stan       <= stan_nxt;
            irq_prev   <= irq_src;
            pending    <= pend_nxt;
            int_req    <= req_nxt;
            int_vec    <= vec_nxt;
            in_service <= srv_nxt;
            if (zapisz_mask) begin
                mask <= wartosc[N_SRC-1:0];
                gie  <= wartosc[7];
            end
        end
    end

    always_comb begin
        pending_o              = '0;
        pending_o[N_SRC-1:0]   = pending;
        mask_o                 = '0;
        mask_o[N_SRC-1:0]      = mask;
        mask_o[7]              = gie;
    end

endmodule

// File: tb/tb_uklad_przerwan.sv
// Directed self-checking bench for uklad_przerwan with hand-computed expectations.
module tb_uklad_przerwan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_src;
    logic [7:0] wartosc;
    logic       zapisz_mask;
    logic       zapisz_clr;
    logic       int_req;
    logic [2:0] int_vec;
    logic       int_ack;
    logic       int_ret;
    logic [7:0] pending_o;
    logic [7:0] mask_o;
    logic       in_service;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uklad_przerwan #(.N_SRC(4), .VEC_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .wartosc     (wartosc),
        .zapisz_mask (zapisz_mask),
        .zapisz_clr  (zapisz_clr),
        .int_req     (int_req),
        .int_vec     (int_vec),
        .int_ack     (int_ack),
        .int_ret     (int_ret),
        .pending_o   (pending_o),
        .mask_o      (mask_o),
        .in_service  (in_service)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_mask(input logic [7:0] v);
        wartosc = v;
        zapisz_mask = 1'b1;
        step();
        zapisz_mask = 1'b0;
    endtask

    task automatic wr_clr(input logic [7:0] v);
        wartosc = v;
        zapisz_clr = 1'b1;
        step();
        zapisz_clr = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        irq_src = 4'b1111;
        wartosc = 8'h00;
        zapisz_mask = 1'b0;
        zapisz_clr = 1'b0;
        int_ack = 1'b0;
        int_ret = 1'b0;

        // Reset with all sources high
        step();
        step();
        chk("rst_req", {7'd0, int_req}, 8'h00);
        chk("rst_vec", {5'd0, int_vec}, 8'h00);
        chk("rst_srv", {7'd0, in_service}, 8'h00);
        chk("rst_pend", pending_o, 8'h00);
        chk("rst_mask", mask_o, 8'h00);

        // Release: held-high lines produce one event each, gie=0 blocks requests
        rst = 1'b1;
        step();
        step();
        step();
        chk("gie0_pend", pending_o, 8'h0F);
        chk("gie0_req", {7'd0, int_req}, 8'h00);
        irq_src = 4'b0000;
        wr_clr(8'h0F);
        chk("clr_all", pending_o, 8'h00);

        // Basic flow
        wr_mask(8'h81);
        chk("mask81", mask_o, 8'h81);
        irq_src = 4'b0001;
        step();
        irq_src = 4'b0000;
        chk("b_pend", pending_o, 8'h01);
        chk("b_req_early", {7'd0, int_req}, 8'h00);
        step();
        chk("b_req", {7'd0, int_req}, 8'h01);
        chk("b_vec", {5'd0, int_vec}, 8'h00);
        pulse_ack();
        chk("b_ack_req", {7'd0, int_req}, 8'h00);
        chk("b_ack_srv", {7'd0, in_service}, 8'h01);
        chk("b_ack_pend", pending_o, 8'h00);
        step();
        pulse_ret();
        chk("b_ret_srv", {7'd0, in_service}, 8'h00);
        chk("b_ret_req", {7'd0, int_req}, 8'h00);

        // Priority and freeze
        wr_mask(8'h8F);
        chk("mask8f", mask_o, 8'h8F);
        irq_src = 4'b1100;
        step();
        step();
        chk("p_req", {7'd0, int_req}, 8'h01);
        chk("p_vec2", {5'd0, int_vec}, 8'h02);
        irq_src = 4'b1101;
        step();
        chk("p_pend", pending_o, 8'h0D);
        chk("p_frz1", {5'd0, int_vec}, 8'h02);
        step();
        chk("p_frz2", {5'd0, int_vec}, 8'h02);
        chk("p_frz_req", {7'd0, int_req}, 8'h01);
        pulse_ack();
        chk("p_ack_pend", pending_o, 8'h09);
        pulse_ret();
        step();
        chk("p_req0", {7'd0, int_req}, 8'h01);
        chk("p_vec0", {5'd0, int_vec}, 8'h00);
        pulse_ack();
        pulse_ret();
        step();
        chk("p_req3", {7'd0, int_req}, 8'h01);
        chk("p_vec3", {5'd0, int_vec}, 8'h03);
        pulse_ack();
        pulse_ret();
        irq_src = 4'b0000;
        step();
        chk("p_end_pend", pending_o, 8'h00);
        chk("p_end_req", {7'd0, int_req}, 8'h00);

        // Withdraw by clearing the requested source
        irq_src = 4'b0010;
        step();
        irq_src = 4'b0000;
        step();
        chk("w_req", {7'd0, int_req}, 8'h01);
        chk("w_vec", {5'd0, int_vec}, 8'h01);
        wr_clr(8'h02);
        chk("w_pend", pending_o, 8'h00);
        step();
        chk("w_req0", {7'd0, int_req}, 8'h00);
        pulse_ack();
        chk("w_ack_ign", {7'd0, in_service}, 8'h00);
        chk("w_ack_req", {7'd0, int_req}, 8'h00);

        // Event during service
        irq_src = 4'b0001;
        step();
        irq_src = 4'b0000;
        step();
        chk("s_vec0", {5'd0, int_vec}, 8'h00);
        pulse_ack();
        chk("s_srv", {7'd0, in_service}, 8'h01);
        irq_src = 4'b0010;
        step();
        irq_src = 4'b0000;
        chk("s_pend", pending_o, 8'h02);
        step();
        step();
        chk("s_noreq", {7'd0, int_req}, 8'h00);
        pulse_ret();
        chk("s_ret_srv", {7'd0, in_service}, 8'h00);
        chk("s_ret_req", {7'd0, int_req}, 8'h00);
        step();
        chk("s_req", {7'd0, int_req}, 8'h01);
        chk("s_vec1", {5'd0, int_vec}, 8'h01);
        pulse_ack();
        pulse_ret();

        // Same-cycle event and clear
        irq_src = 4'b0001;
        wr_clr(8'h01);
        irq_src = 4'b0000;
        chk("e_pend", pending_o, 8'h01);
        step();
        chk("e_req", {7'd0, int_req}, 8'h01);
        pulse_ack();
        pulse_ret();

        // Held-high source gives one request only
        irq_src = 4'b0010;
        step();
        step();
        chk("h_req", {7'd0, int_req}, 8'h01);
        chk("h_vec", {5'd0, int_vec}, 8'h01);
        pulse_ack();
        pulse_ret();
        step();
        step();
        chk("h_noreq", {7'd0, int_req}, 8'h00);
        chk("h_pend", pending_o, 8'h00);
        irq_src = 4'b0000;

        // Asynchronous reset mid-request
        irq_src = 4'b0001;
        step();
        irq_src = 4'b0000;
        step();
        chk("m_req", {7'd0, int_req}, 8'h01);
        #2;
        rst = 1'b0;
        #1;
        chk("m_rst_req", {7'd0, int_req}, 8'h00);
        chk("m_rst_mask", mask_o, 8'h00);
        chk("m_rst_pend", pending_o, 8'h00);
        step();
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
